mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between instruction fetch and the data load/store path.
- Arbitrates between the two requesters with data priority plus an anti-starvation bound.
- Formats stores into byte enables and replicated write data; extends load data according to funct3.
- Sits between the core (fetch stage, MemSrc/MemWrite path) and the memory model; the core stalls on the missing valid pulses.

Parameters:
- AW, 32, byte-address width.
- MAX_D_RUN, 4, maximum consecutive data grants while if_req is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_valid.
- if_addr  in  AW  fetch byte address; bits [1:0] ignored.
- if_rdata  out  32  fetched word.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- d_req  in  1  data request; held with d_we, d_funct3, d_addr and d_wdata until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  size/sign code (MemSrc).
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data in the low bits.
- d_rdata  out  32  extended load data.
- d_valid  out  1  one-cycle pulse: load data valid / store done.
- d_err  out  1  misaligned access flag (see Optional Feature).
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write.
- mem_addr  out  AW  word-aligned address ([1:0] = 0).
- mem_wdata  out  32  replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  read word, valid together with mem_ready.
- mem_ready  in  1  completion; sampled only while mem_req = 1.

Behaviour:
- Reset: state IDLE; run counter 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_valid, if_rdata, d_valid, d_rdata, d_err.
  - Reset asserted mid-transaction drops mem_req asynchronously; any later mem_ready is ignored; no valid pulse is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Samples requests, selects a winner, registers address/control/data for the winner, then goes to WAIT.
  - Selection: data wins, unless if_req = 1 and run counter = MAX_D_RUN, in which case fetch wins.
  - Run counter: increments on a data grant while if_req = 1; clears on a fetch grant or on a data grant with if_req = 0; saturates at MAX_D_RUN.
- WAIT:
  - mem_req = 1; address, control and data are stable from registers.
  - On mem_ready: captures the formatted result, goes to RESP, and drops mem_req in the same edge.
- RESP:
  - Exactly one cycle; the winner's valid pulses; then IDLE.
  - A requester still asserting req in the cycle after its valid pulse is treated as issuing a new request.
- Latency: req at cycle 0 → mem_req at cycle 1 → mem_ready at cycle N ≥ 1 → valid at N+1.
  - Minimum latency is 2 cycles; throughput is at most one access per 3 cycles.
- if_rdata/d_rdata hold their last value outside valid pulses. Fetch always performs a word read with mem_be = 4'b1111, mem_we = 0.
- Stores (funct3 = 000 SB, 001 SH, 010 SW):
  - mem_be: SB = 1 << addr[1:0]; SH = 4'b0011 << (2·addr[1]); SW = 4'b1111.
  - mem_wdata: byte replicated ×4, half replicated ×2, or the word as is.
  - d_rdata is unchanged on stores.
- Loads:
  - Select the lane by addr[1:0].
  - Extension: 000 LB sign-extend byte; 100 LBU zero-extend byte; 001 LH sign-extend half; 101 LHU zero-extend half; 010 LW whole word.
  - For loads, mem_be = 4'b1111.
- Other funct3 codes are treated as a word access.
- Requests change only in IDLE; requester inputs are ignored in WAIT/RESP.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - A data request is misaligned if it is a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
  - A misaligned request is granted normally but issues no memory access: IDLE → RESP directly.
  - d_valid = 1 and d_err = 1 for that one cycle; d_rdata = 0; the run counter updates as for a normal data grant.
- Undefined:
  - d_err is tied 0.
  - Halves use addr[1] and ignore addr[0]; words ignore addr[1:0].

Decomposition:
- Package mem_pkg:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum arb_state_t {IDLE, WAIT, RESP}.
  - Grant enum grant_t {G_IF, G_D}.
- One combinational sub-module, ls_align: inputs funct3, addr[1:0], wdata, rdata; outputs be, mem_wdata, extended rdata and misaligned.

Test Plan:
- Fetch only: if_req, if_addr = 0x100, memory returns 0xDEADBEEF with 3-cycle latency → mem_addr = 0x100, mem_be = 1111, if_valid pulses once at cycle 5, if_rdata = 0xDEADBEEF.
- SB at 0x203, d_wdata = 0x000000A5 → mem_we = 1, mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x200, one d_valid pulse.
- LB/LBU at 0x201, mem_rdata = 0x0000F000 → LB gives d_rdata = 0xFFFFFFF0; LBU gives 0x000000F0. LH at 0x202 with 0x80000000 → 0xFFFF8000.
- Starvation: if_req and d_req held high continuously, zero-latency ready → data granted 4 times, then fetch once, repeating; neither valid is ever lost.
- Simultaneous first requests → data granted first; fetch granted after the d_valid cycle. Reset asserted in WAIT → mem_req drops immediately; a mem_ready pulse afterwards produces no valid pulse.
- MEM_ALIGN_CHECK_EN: LW at 0x102 → no mem_req, d_valid = d_err = 1 one cycle after the request, d_rdata = 0. Without the macro → word read at 0x100, d_err = 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Package : mem_pkg
// Desc    : Shared funct3 codes, arbiter state and grant encodings for the
//           unified-memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Load/store size and sign codes carried on d_funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    G_IF = 1'b0,
    G_D  = 1'b1
  } grant_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_ls_align.sv
// ============================================================================
// Module : ls_align
// Desc   : Combinational lane steering for the data path. Builds byte enables
//          and replicated store data, extends load data by funct3, and flags
//          accesses whose address does not match their size.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ls_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_mem_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte lane out of the returned word
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // Halves only look at addr[1]; addr[0] is the misalignment indicator
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Size decode: byte and half codes get lane logic, everything else is a word
  always_comb begin
    o_be         = 4'b1111;
    o_mem_wdata  = i_wdata;
    o_rdata      = i_rdata;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be        = 4'b0001 << i_addr;
        o_mem_wdata = {4{i_wdata[7:0]}};
        o_rdata     = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                         : {24'd0, w_byte};
      end
      F3_H, F3_HU: begin
        o_be         = 4'b0011 << {i_addr[1], 1'b0};
        o_mem_wdata  = {2{i_wdata[15:0]}};
        o_rdata      = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                          : {16'd0, w_half};
        o_misaligned = i_addr[0];
      end
      F3_W: begin
        o_misaligned = |i_addr;
      end
      default: begin
        o_misaligned = |i_addr;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Desc   : Shares one single-port, variable-latency memory between instruction
//          fetch and the data load/store path. Data has priority, but fetch is
//          forced after MAX_D_RUN back-to-back data grants while it waits.
// Config : MEM_ALIGN_CHECK_EN - when defined, misaligned half/word data
//          accesses complete immediately with d_err and no memory access.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int MAX_D_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_funct3,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam int              RW          = $clog2(MAX_D_RUN + 1);
  localparam logic [RW-1:0]   c_RUN_MAX   = RW'(MAX_D_RUN);
  localparam logic [AW-1:0]   c_WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  arb_state_t      r_state;
  grant_t          r_grant;
  logic [RW-1:0]   r_run;
  logic [2:0]      r_funct3;
  logic [1:0]      r_lane;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [3:0]      r_mem_be;
  logic            r_if_valid;
  logic [31:0]     r_if_rdata;
  logic            r_d_valid;
  logic [31:0]     r_d_rdata;
  logic            r_d_err;

  logic [2:0]      w_funct3;
  logic [1:0]      w_lane;
  logic [3:0]      w_be;
  logic [31:0]     w_fmt_wdata;
  logic [31:0]     w_ext_rdata;
  logic            w_misaligned;
  logic            w_err_go;
  logic            w_pick_d;
  logic [RW-1:0]   w_run_next;

  // In IDLE the aligner formats the incoming store; afterwards it decodes
  // the returning load with the size/lane captured at grant time.
  assign w_funct3 = (r_state == IDLE) ? d_funct3    : r_funct3;
  assign w_lane   = (r_state == IDLE) ? d_addr[1:0] : r_lane;

  ls_align u_align (
    .i_funct3     (w_funct3),
    .i_addr       (w_lane),
    .i_wdata      (d_wdata),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_mem_wdata  (w_fmt_wdata),
    .o_rdata      (w_ext_rdata),
    .o_misaligned (w_misaligned)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign w_err_go = w_misaligned;
`else
  logic w_unused_misaligned;
  assign w_err_go            = 1'b0;
  assign w_unused_misaligned = w_misaligned;
`endif

  // Data wins unless fetch has been waiting through a full run of data grants
  assign w_pick_d   = d_req && !(if_req && (r_run == c_RUN_MAX));
  assign w_run_next = (r_run == c_RUN_MAX) ? r_run : r_run + RW'(1);

  // Arbitration FSM: grant in IDLE, hold the access in WAIT, pulse in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= G_IF;
      r_run       <= '0;
      r_funct3    <= '0;
      r_lane      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_valid   <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_grant     <= G_D;
            r_funct3    <= d_funct3;
            r_lane      <= d_addr[1:0];
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr & c_WORD_MASK;
            r_mem_be    <= d_we ? w_be : 4'b1111;
            r_mem_wdata <= w_fmt_wdata;
            r_run       <= if_req ? w_run_next : '0;
            if (w_err_go) begin
              // Misaligned: answer straight away without touching memory
              r_state   <= RESP;
              r_d_valid <= 1'b1;
              r_d_err   <= 1'b1;
              r_d_rdata <= '0;
            end else begin
              r_state   <= WAIT;
              r_mem_req <= 1'b1;
            end
          end else if (if_req) begin
            r_grant     <= G_IF;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr & c_WORD_MASK;
            r_mem_be    <= 4'b1111;
            r_mem_wdata <= '0;
            r_run       <= '0;
            r_state     <= WAIT;
            r_mem_req   <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= RESP;
            if (r_grant == G_D) begin
              r_d_valid <= 1'b1;
              if (!r_mem_we) begin
                r_d_rdata <= w_ext_rdata;
              end
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Desc   : Self-checking bench for mem_arbiter. A transaction-level model
//          predicts grants, memory-side fields and response data each cycle;
//          directed cases pin literal results. Honours MEM_ALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int AW        = 32;
  localparam int MAX_D_RUN = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit c_ALIGN = 1'b1;
`else
  localparam bit c_ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [2:0]    d_funct3 = 3'b010;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_arbiter #(.AW(AW), .MAX_D_RUN(MAX_D_RUN)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_off(input int s, input logic [31:0] a);
    return (s == 1) ? int'(a[1:0]) : (s == 2) ? int'(a[1]) * 2 : 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    logic [3:0] b;
    if (!we || s == 4) return 4'hF;
    b = (s == 1) ? 4'b0001 : 4'b0011;
    return b << lane_off(s, a);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int s = size_of(f3);
    if (s == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (s == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int s = size_of(f3);
    longint v, lim;
    if (s == 4) return w;
    v   = longint'(w >> (8 * lane_off(s, a))) % (longint'(1) << (8 * s));
    lim = longint'(1) << (8 * s - 1);
    if (!f3[2] && v >= lim) v = v - 2 * lim;
    return v[31:0];
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
  endfunction

  // ---------------- model state ----------------
  int          m_phase = 0;   // 0 free, 1 memory access outstanding, 2 response cycle
  bit          m_win_d;
  bit          m_err;
  int          m_dstreak = 0;
  logic        m_we;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_if_rdata = '0, m_d_rdata = '0;

  // captures for directed literal checks
  int          win_q[$];
  int          n_memreq = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_err;

  // Memory responder: ready after g_lat idle cycles of mem_req
  int          g_lat = 0;
  logic [31:0] g_rdata = '0;
  bit          g_auto = 1'b1;
  int          rsp_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (g_auto) begin
      if (mem_req) begin
        if (rsp_cnt == g_lat) begin
          mem_ready = 1'b1;
          mem_rdata = g_rdata;
        end else begin
          mem_ready = 1'b0;
          rsp_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        rsp_cnt   = 0;
      end
    end
  end

  // Model update and per-cycle comparison
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      m_phase = 0; m_dstreak = 0; m_if_rdata = '0; m_d_rdata = '0;
      chk("rst mem_req",   32'(mem_req),   32'd0);
      chk("rst mem_we",    32'(mem_we),    32'd0);
      chk("rst mem_addr",  mem_addr,       32'd0);
      chk("rst mem_wdata", mem_wdata,      32'd0);
      chk("rst mem_be",    32'(mem_be),    32'd0);
      chk("rst if_valid",  32'(if_valid),  32'd0);
      chk("rst if_rdata",  if_rdata,       32'd0);
      chk("rst d_valid",   32'(d_valid),   32'd0);
      chk("rst d_rdata",   d_rdata,        32'd0);
      chk("rst d_err",     32'(d_err),     32'd0);
    end else begin
      case (m_phase)
        0: begin
          if (d_req && !(if_req && m_dstreak >= MAX_D_RUN)) begin
            m_win_d = 1'b1; m_we = d_we; m_f3 = d_funct3; m_addr = d_addr; m_wd = d_wdata;
            m_dstreak = if_req ? ((m_dstreak < MAX_D_RUN) ? m_dstreak + 1 : m_dstreak) : 0;
            m_err = c_ALIGN && ref_misaligned(d_funct3, d_addr);
            if (m_err) begin
              m_phase = 2; m_d_rdata = '0;
            end else begin
              m_phase = 1;
            end
          end else if (if_req) begin
            m_win_d = 1'b0; m_we = 1'b0; m_f3 = 3'b010; m_addr = if_addr; m_wd = '0;
            m_dstreak = 0; m_err = 1'b0; m_phase = 1;
          end
        end
        1: begin
          if (mem_ready) begin
            m_phase = 2;
            if (!m_win_d) m_if_rdata = mem_rdata;
            else if (!m_we) m_d_rdata = ref_load(m_f3, m_addr, mem_rdata);
          end
        end
        default: m_phase = 0;
      endcase

      chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
      if (m_phase == 1) begin
        chk("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
        chk("mem_we",   32'(mem_we), 32'(m_we));
        chk("mem_be",   32'(mem_be), 32'(ref_be(m_we, m_f3, m_addr)));
        if (m_we) chk("mem_wdata", mem_wdata, ref_wdata(m_f3, m_wd));
      end
      chk("if_valid", 32'(if_valid), 32'(m_phase == 2 && !m_win_d));
      chk("d_valid",  32'(d_valid),  32'(m_phase == 2 && m_win_d));
      chk("d_err",    32'(d_err),    32'(m_phase == 2 && m_err));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata",  d_rdata,  m_d_rdata);

      if (mem_req) begin
        n_memreq++;
        cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
      end
      if (d_valid) begin
        win_q.push_back(1);
        cap_err = d_err;
      end
      if (if_valid) win_q.push_back(0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid(input int t0, output int lat_cyc);
    int n = 0;
    @(posedge clk); #2;
    while (!(if_valid || d_valid) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) begin
      n_vec++; n_err++;
      $display("FAIL valid timeout: got none expected pulse within 100 cycles");
    end
    lat_cyc = cyc - t0;
  endtask

  task automatic d_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int lat,
                       output int lat_cyc);
    int t0;
    @(negedge clk);
    g_rdata = rd; g_lat = lat;
    d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
    t0 = cyc;
    wait_valid(t0, lat_cyc);
    @(negedge clk);
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, t0, n, mr0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch only, 3-cycle memory latency
    @(negedge clk);
    g_rdata = 32'hDEADBEEF; g_lat = 3; if_addr = 32'h100; if_req = 1'b1; t0 = cyc;
    wait_valid(t0, lc);
    @(negedge clk); if_req = 1'b0;
    chk("fetch latency",  32'(lc),     32'd5);
    chk("fetch mem_addr", cap_addr,    32'h100);
    chk("fetch mem_be",   32'(cap_be), 32'hF);
    chk("fetch if_rdata", if_rdata,    32'hDEADBEEF);

    // SB at 0x203
    d_txn(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1, lc);
    chk("sb mem_we",    32'(cap_we), 32'd1);
    chk("sb mem_be",    32'(cap_be), 32'h8);
    chk("sb mem_wdata", cap_wdata,   32'hA5A5A5A5);
    chk("sb mem_addr",  cap_addr,    32'h200);

    // Loads with extension
    d_txn(1'b0, 3'b000, 32'h201, 32'h0, 32'h0000F000, 2, lc);
    chk("lb d_rdata",  d_rdata, 32'hFFFFFFF0);
    d_txn(1'b0, 3'b100, 32'h201, 32'h0, 32'h0000F000, 1, lc);
    chk("lbu d_rdata", d_rdata, 32'h000000F0);
    d_txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h80000000, 0, lc);
    chk("lh d_rdata",  d_rdata, 32'hFFFF8000);
    d_txn(1'b0, 3'b101, 32'h200, 32'h0, 32'h1234F00D, 0, lc);
    chk("lhu d_rdata", d_rdata, 32'h0000F00D);
    d_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0, lc);
    chk("lw d_rdata",  d_rdata, 32'hCAFEF00D);
    chk("min latency", 32'(lc), 32'd2);

    // SH upper half, SW
    d_txn(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, lc);
    chk("sh mem_be",    32'(cap_be), 32'hC);
    chk("sh mem_wdata", cap_wdata,   32'hABCDABCD);
    chk("sh d_rdata kept", d_rdata,  32'hCAFEF00D);
    d_txn(1'b1, 3'b010, 32'h104, 32'h1234ABCD, 32'h0, 0, lc);
    chk("sw mem_be",    32'(cap_be), 32'hF);
    chk("sw mem_wdata", cap_wdata,   32'h1234ABCD);

    // LW at 0x102: error response with the check enabled, word read otherwise
    mr0 = n_memreq;
    d_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h55AA55AA, 1, lc);
    if (c_ALIGN) begin
      chk("misal no mem_req", 32'(n_memreq - mr0), 32'd0);
      chk("misal latency",    32'(lc),      32'd1);
      chk("misal d_err",      32'(cap_err), 32'd1);
      chk("misal d_rdata",    d_rdata,      32'd0);
    end else begin
      chk("lw102 mem_addr",   cap_addr,     32'h100);
      chk("lw102 d_err",      32'(cap_err), 32'd0);
      chk("lw102 d_rdata",    d_rdata,      32'h55AA55AA);
    end

    // Simultaneous first requests: data first, then fetch
    win_q.delete();
    @(negedge clk);
    g_lat = 1; g_rdata = 32'h0BADF00D;
    if_addr = 32'h40; if_req = 1'b1;
    d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h80; d_req = 1'b1; t0 = cyc;
    wait_valid(t0, lc);
    @(negedge clk); d_req = 1'b0;
    wait_valid(cyc, lc);
    @(negedge clk); if_req = 1'b0;
    chk("simul count", 32'(win_q.size()), 32'd2);
    if (win_q.size() >= 2) begin
      chk("simul first is data",   32'(win_q[0]), 32'd1);
      chk("simul second is fetch", 32'(win_q[1]), 32'd0);
    end

    // Starvation bound: both held, zero-latency memory
    win_q.delete();
    @(negedge clk);
    g_lat = 0; g_rdata = 32'h13572468;
    if_addr = 32'h20; if_req = 1'b1;
    d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10; d_req = 1'b1;
    n = 0;
    while (win_q.size() < 15 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if_req = 1'b0; d_req = 1'b0;
    if (n >= 300) begin
      n_vec++; n_err++;
      $display("FAIL starve timeout: got %0d grants expected 15", win_q.size());
    end
    repeat (6) @(negedge clk);
    chk("starve count", 32'(win_q.size()), 32'd15);
    for (int i = 0; i < 15 && i < win_q.size(); i++)
      chk($sformatf("starve grant %0d", i), 32'(win_q[i]), (i % 5 == 4) ? 32'd0 : 32'd1);

    // Reset while waiting on memory
    win_q.delete();
    @(negedge clk);
    g_lat = 20; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h500; d_req = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset mem_req", 32'(mem_req), 32'd0);
    chk("async reset d_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    d_req = 1'b0; g_auto = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rdata = 32'hFFFFFFFF; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("late ready no valid", 32'(win_q.size()), 32'd0);
    chk("late ready no req",   32'(mem_req),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
